// File: rtl/tpu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tpu_seq
// Description : Command sequencer for the tpuv1 matrix unit. A job loads DIM
//               A rows and DIM B rows from a valid/ready operand stream into
//               tpuv1's memory-mapped port, issues the matmul command, waits
//               out the systolic pass and then streams the DIM x DIM C result
//               out as 2*DIM half-row words on a valid/ready result stream.
//               This block is the only master of tpuv1 addr/r_w/dataIn.
// Revision    : 1.0 - initial release
//
// Build option:
//   TPU_SEQ_CLEAR_C_EN  defined   -> each job starts with a CLR pass that
//                                    writes zero to every C half-row, so the
//                                    result is A*B.
//                       undefined -> no CLR pass; C accumulates across jobs
//                                    (C += A*B) and the host owns clearing.
//
// Ports:
//   clk          in   1      clock
//   rst          in   1      synchronous active-high reset
//   start        in   1      begin a job (sampled only in IDLE)
//   busy         out  1      high in every state except IDLE
//   done         out  1      one-cycle pulse on the last cycle of a job
//   in_valid     in   1      operand stream valid
//   in_ready     out  1      operand stream ready (LDA/LDB only)
//   in_data      in   DATAW  operand word: A rows then B rows
//   out_valid    out  1      result stream valid
//   out_ready    in   1      result stream ready
//   out_data     out  DATAW  C half-row word (registered)
//   out_last     out  1      marks the final result word
//   tpu_addr     out  ADDRW  tpuv1 address
//   tpu_r_w      out  1      tpuv1 read/write, 1 = write
//   tpu_dataIn   out  DATAW  tpuv1 write data
//   tpu_dataOut  in   DATAW  tpuv1 read data (combinational in tpu_addr)
// ============================================================================
module tpu_seq #(
    parameter int DIM       = 8,
    parameter int BITS_AB   = 8,
    parameter int BITS_C    = 16,
    parameter int ADDRW     = 16,
    parameter int DATAW     = 64,
    parameter int MM_CYCLES = DIM * 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_last,
    output logic [ADDRW-1:0] tpu_addr,
    output logic             tpu_r_w,
    output logic [DATAW-1:0] tpu_dataIn,
    input  logic [DATAW-1:0] tpu_dataOut
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_nwords = 2 * DIM;
    localparam int c_iw     = $clog2(c_nwords);
    localparam int c_ww     = (MM_CYCLES > 1) ? $clog2(MM_CYCLES) : 1;

    localparam logic [c_iw-1:0] c_last_row  = c_iw'(DIM - 1);
    localparam logic [c_iw-1:0] c_last_word = c_iw'(c_nwords - 1);
    localparam logic [c_iw-1:0] c_idx_one   = c_iw'(1);
    localparam logic [c_ww-1:0] c_wait_init = c_ww'(MM_CYCLES - 1);
    localparam logic [c_ww-1:0] c_wait_one  = c_ww'(1);

    // tpuv1 region bases
    localparam logic [ADDRW-1:0] c_addr_a  = ADDRW'(32'h100);
    localparam logic [ADDRW-1:0] c_addr_b  = ADDRW'(32'h200);
    localparam logic [ADDRW-1:0] c_addr_c  = ADDRW'(32'h300);
    localparam logic [ADDRW-1:0] c_addr_mm = ADDRW'(32'h400);

    // ------------------------------------------------------------------------
    // Elaboration-time sanity check on the parameter set: a C half-row must
    // exactly fill a data word and DIM must be a power of two so that the
    // row/half index maps onto contiguous address bits.
    // ------------------------------------------------------------------------
    if (((DIM / 2) * BITS_C != DATAW) || (BITS_AB > BITS_C) || (DIM < 2) ||
        ((DIM & (DIM - 1)) != 0)) begin : g_bad_cfg
        $error("tpu_seq: inconsistent DIM/BITS_AB/BITS_C/DATAW parameters");
    end

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LDA  = 3'd2,
        S_LDB  = 3'd3,
        S_MM   = 3'd4,
        S_WAIT = 3'd5,
        S_RDC  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t             r_state_q;
    state_t             w_state_d;
    logic [c_iw-1:0]    r_idx_q;        // row (LDA/LDB) or {row,half} (CLR/RDC)
    logic [c_iw-1:0]    w_idx_d;
    logic [c_ww-1:0]    r_wait_q;       // WAIT down-counter
    logic [c_ww-1:0]    w_wait_d;
    logic               r_out_valid_q;
    logic               w_out_valid_d;
    logic               r_out_last_q;
    logic               w_out_last_d;
    logic [DATAW-1:0]   r_out_data_q;
    logic [DATAW-1:0]   w_out_data_d;

    // The output register can take a new word whenever it is empty or its
    // current word is being consumed this cycle.
    logic               w_drain;
    logic               w_load;

    assign w_drain = !r_out_valid_q || out_ready;

    always_comb begin
        w_state_d     = r_state_q;
        w_idx_d       = r_idx_q;
        w_wait_d      = r_wait_q;
        w_out_valid_d = r_out_valid_q;
        w_out_last_d  = r_out_last_q;
        w_out_data_d  = r_out_data_q;
        w_load        = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_idx_d = '0;
`ifdef TPU_SEQ_CLEAR_C_EN
                    w_state_d = S_CLR;
`else
                    w_state_d = S_LDA;
`endif
                end
            end
`ifdef TPU_SEQ_CLEAR_C_EN
            S_CLR: begin
                // One zero write per C half-row, no handshake involved.
                if (r_idx_q == c_last_word) begin
                    w_idx_d   = '0;
                    w_state_d = S_LDA;
                end else begin
                    w_idx_d = r_idx_q + c_idx_one;
                end
            end
`endif
            S_LDA: begin
                if (in_valid) begin
                    if (r_idx_q == c_last_row) begin
                        w_idx_d   = '0;
                        w_state_d = S_LDB;
                    end else begin
                        w_idx_d = r_idx_q + c_idx_one;
                    end
                end
            end
            S_LDB: begin
                if (in_valid) begin
                    if (r_idx_q == c_last_row) begin
                        w_idx_d   = '0;
                        w_state_d = S_MM;
                    end else begin
                        w_idx_d = r_idx_q + c_idx_one;
                    end
                end
            end
            S_MM: begin
                w_wait_d  = c_wait_init;
                w_state_d = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_q == '0) begin
                    w_idx_d   = '0;
                    w_state_d = S_RDC;
                end else begin
                    w_wait_d = r_wait_q - c_wait_one;
                end
            end
            S_RDC: begin
                // Backpressure only freezes the read index; the address bus
                // follows the index so the same half-row is re-presented.
                if (w_drain) begin
                    w_load = 1'b1;
                    if (r_idx_q == c_last_word) begin
                        w_idx_d   = '0;
                        w_state_d = S_DONE;
                    end else begin
                        w_idx_d = r_idx_q + c_idx_one;
                    end
                end
            end
            S_DONE: begin
                // Leave once the final word is gone or leaving this cycle.
                if (w_drain) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_out_data_d  = tpu_dataOut;
            w_out_valid_d = 1'b1;
            w_out_last_d  = (r_idx_q == c_last_word);
        end else if (out_ready) begin
            w_out_valid_d = 1'b0;
            w_out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_idx_q       <= '0;
            r_wait_q      <= '0;
            r_out_valid_q <= 1'b0;
            r_out_last_q  <= 1'b0;
            r_out_data_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_idx_q       <= w_idx_d;
            r_wait_q      <= w_wait_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_last_q  <= w_out_last_d;
            r_out_data_q  <= w_out_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Status and stream outputs
    // ------------------------------------------------------------------------
    assign busy      = (r_state_q != S_IDLE);
    // done must coincide with the final DONE cycle, which depends on the
    // consumer's out_ready in that same cycle.
    assign done      = (r_state_q == S_DONE) && w_drain;
    assign in_ready  = (r_state_q == S_LDA) || (r_state_q == S_LDB);
    assign out_valid = r_out_valid_q;
    assign out_last  = r_out_last_q;
    assign out_data  = r_out_data_q;

    // ------------------------------------------------------------------------
    // tpuv1 bus. Idle value is addr=0 / r_w=0 / dataIn=0 (region 0, no-op).
    // Operand writes are forwarded in the handshake cycle with no register.
    // ------------------------------------------------------------------------
    always_comb begin
        tpu_addr   = '0;
        tpu_r_w    = 1'b0;
        tpu_dataIn = '0;

        case (r_state_q)
`ifdef TPU_SEQ_CLEAR_C_EN
            S_CLR: begin
                // idx = {row, half}, so idx<<3 == row<<4 | half<<3
                tpu_addr = c_addr_c | (ADDRW'(r_idx_q) << 3);
                tpu_r_w  = 1'b1;
            end
`endif
            S_LDA: begin
                if (in_valid) begin
                    tpu_addr   = c_addr_a | (ADDRW'(r_idx_q) << 3);
                    tpu_r_w    = 1'b1;
                    tpu_dataIn = in_data;
                end
            end
            S_LDB: begin
                // B rows are pushed to a single port in arrival order.
                if (in_valid) begin
                    tpu_addr   = c_addr_b;
                    tpu_r_w    = 1'b1;
                    tpu_dataIn = in_data;
                end
            end
            S_MM: begin
                tpu_addr = c_addr_mm;
                tpu_r_w  = 1'b1;
            end
            S_RDC: begin
                tpu_addr = c_addr_c | (ADDRW'(r_idx_q) << 3);
            end
            default: begin
                tpu_addr   = '0;
                tpu_r_w    = 1'b0;
                tpu_dataIn = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tpu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpu_seq
// Description : Self-checking bench for tpu_seq. Contains a memory-mapped
//               stand-in for tpuv1, a job-level model of the expected C words
//               and directed job scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_seq;

    localparam int DIM = 8;
    localparam int NW  = 2 * DIM;
`ifdef TPU_SEQ_CLEAR_C_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif
    localparam int          EXP_LAT = CLR_EN ? 82 : 66;
    localparam logic [63:0] ACC_LIT = CLR_EN ? 64'h0002_0002_0002_0002
                                             : 64'h0004_0004_0004_0004;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic [15:0] tpu_addr;
    logic        tpu_r_w;
    logic [63:0] tpu_dataIn;
    logic [63:0] tpu_dataOut;

    tpu_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .tpu_addr   (tpu_addr),
        .tpu_r_w    (tpu_r_w),
        .tpu_dataIn (tpu_dataIn),
        .tpu_dataOut(tpu_dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errs   = 0;
    int cyc         = 0;
    int ready_total = 0;
    int done_total  = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (in_ready) ready_total <= ready_total + 1;
        if (done)     done_total  <= done_total + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- tpuv1 stand-in ----------------
    logic [63:0] sa [DIM];
    logic [63:0] sb [DIM];
    logic [15:0] sc [DIM][DIM];
    int          bptr;

    function automatic logic [15:0] dot(input int i, input int j);
        logic [15:0] s;
        s = 16'd0;
        for (int k = 0; k < DIM; k++)
            s = s + 16'(sa[i][k*8 +: 8]) * 16'(sb[k][j*8 +: 8]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++)
                    sc[i][j] <= 16'd0;
            bptr <= 0;
        end else if (tpu_r_w) begin
            case (tpu_addr[11:8])
                4'h1: sa[tpu_addr[5:3]] <= tpu_dataIn;
                4'h2: begin
                    sb[bptr % DIM] <= tpu_dataIn;
                    bptr <= bptr + 1;
                end
                4'h3: begin
                    for (int l = 0; l < 4; l++)
                        sc[tpu_addr[6:4]][tpu_addr[3]*4 + l] <= tpu_dataIn[l*16 +: 16];
                end
                4'h4: begin
                    for (int i = 0; i < DIM; i++)
                        for (int j = 0; j < DIM; j++)
                            sc[i][j] <= sc[i][j] + dot(i, j);
                    bptr <= 0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tpu_dataOut = 64'd0;
        if (tpu_addr[11:8] == 4'h3)
            for (int l = 0; l < 4; l++)
                tpu_dataOut[l*16 +: 16] = sc[tpu_addr[6:4]][tpu_addr[3]*4 + l];
    end

    // ---------------- job-level model ----------------
    logic [7:0]  ja [DIM][DIM];
    logic [7:0]  jb [DIM][DIM];
    logic [15:0] mc [DIM][DIM];
    logic [64:0] exp_q [$];   // {last, data}
    logic [63:0] got [NW];
    int          rx_idx = 0;
    int          beat_g = 0;
    int          start_cyc = 0;

    function automatic void mc_clear();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                mc[i][j] = 16'd0;
    endfunction

    function automatic void push_expected();
        logic [15:0] s;
        logic [63:0] w;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                s = 16'd0;
                for (int k = 0; k < DIM; k++)
                    s = s + 16'(ja[i][k]) * 16'(jb[k][j]);
                mc[i][j] = (CLR_EN ? 16'd0 : mc[i][j]) + s;
            end
        for (int i = 0; i < DIM; i++)
            for (int h = 0; h < 2; h++) begin
                for (int l = 0; l < 4; l++)
                    w[l*16 +: 16] = mc[i][h*4 + l];
                exp_q.push_back({(i == DIM - 1) && (h == 1), w});
            end
    endfunction

    function automatic logic [63:0] beat_word(input int b);
        logic [63:0] w;
        for (int j = 0; j < DIM; j++)
            w[j*8 +: 8] = (b < DIM) ? ja[b][j] : jb[b - DIM][j];
        return w;
    endfunction

    function automatic void set_ident_job(input int bsel);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ja[i][j] = (i == j) ? 8'd1 : 8'd0;
                jb[i][j] = (bsel == 0) ? 8'(i + 1) : 8'd2;
            end
    endfunction

    function automatic void set_rand_job();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ja[i][j] = 8'($urandom_range(0, 255));
                jb[i][j] = 8'($urandom_range(0, 255));
            end
    endfunction

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin : cmp
        logic [64:0] e;
        logic [15:0] ea;
        if (!rst) begin
            if (in_ready && in_valid) begin
                ea = (beat_g < DIM) ? (16'h100 | 16'(beat_g << 3)) : 16'h200;
                chk("wr_addr", 64'(tpu_addr), 64'(ea));
                chk("wr_rw", 64'(tpu_r_w), 64'd1);
                chk("wr_data", tpu_dataIn, in_data);
            end else if (in_ready) begin
                chk("gap_addr", 64'(tpu_addr), 64'd0);
            end
            if (out_valid && out_ready) begin
                chk("word_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e[63:0]);
                    chk("out_last", 64'(out_last), 64'(e[64]));
                    if (rx_idx < NW) got[rx_idx] = out_data;
                    rx_idx++;
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        mc_clear();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic start_job(input bit toggle);
        bit hs;
        bit gap;
        bit first;
        int guard;
        push_expected();
        rx_idx = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        beat_g   = 0;
        gap      = 1'b0;
        first    = 1'b1;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = beat_word(0);
        while (beat_g < NW && guard < 600) begin
            @(negedge clk);
            if (first) begin
                start_cyc = cyc;
                first = 1'b0;
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) begin
                beat_g++;
                gap = toggle;
            end else begin
                gap = 1'b0;
            end
            in_valid = (beat_g < NW) && !gap;
            in_data  = (beat_g < NW) ? beat_word(beat_g) : 64'd0;
            guard++;
        end
        in_valid = 1'b0;
        chk("feed_complete", 64'(beat_g), 64'(NW));
    endtask

    task automatic wait_done(input int limit, output int lat);
        int n;
        n   = 0;
        lat = -1;
        while (n < limit) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - start_cyc;
                break;
            end
            n++;
        end
        chk("done_seen", 64'(lat >= 0), 64'd1);
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- scenarios ----------------
    initial begin : main
        int lat;
        int snap;
        int dsnap;
        int n;
        logic [63:0] w0;

        rst = 1'b1; start = 1'b1; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b1;
        mc_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        // start held together with rst: reset wins
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_done",      64'(done), 64'd0);
        chk("rst_in_ready",  64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  out_data, 64'd0);
        chk("rst_out_last",  64'(out_last), 64'd0);
        chk("rst_addr",      64'(tpu_addr), 64'd0);
        chk("rst_rw",        64'(tpu_r_w), 64'd0);
        chk("rst_dataIn",    tpu_dataIn, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;

        // 1: A = I, B row r = r+1, unstalled
        set_ident_job(0);
        snap = ready_total;
        start_job(1'b0);
        wait_done(400, lat);
        chk("latency", 64'(lat), 64'(EXP_LAT));
        @(posedge clk); #1;
        chk("ready_cycles", 64'(ready_total - snap), 64'd16);
        chk("lit_w0",  got[0],  64'h0001_0001_0001_0001);
        chk("lit_w1",  got[1],  64'h0001_0001_0001_0001);
        chk("lit_w5",  got[5],  64'h0003_0003_0003_0003);
        chk("lit_w14", got[14], 64'h0008_0008_0008_0008);
        chk("lit_w15", got[15], 64'h0008_0008_0008_0008);

        // 2: same job with in_valid gapped after every beat
        do_reset();
        snap = ready_total;
        start_job(1'b1);
        wait_done(400, lat);
        @(posedge clk); #1;
        chk("ready_cycles_gap", 64'(ready_total - snap), 64'd31);
        chk("gap_lit_w2",  got[2],  64'h0002_0002_0002_0002);
        chk("gap_lit_w15", got[15], 64'h0008_0008_0008_0008);

        // 3: output backpressure for 5 cycles after the first word
        do_reset();
        set_rand_job();
        out_ready = 1'b0;
        start_job(1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_first_valid", 64'(out_valid), 64'd1);
        w0 = out_data;
        chk("stall_word0", w0, exp_q[0][63:0]);
        chk("stall_addr0", 64'(tpu_addr), 64'h308);
        repeat (4) begin
            @(negedge clk);
            chk("stall_hold_data", out_data, w0);
            chk("stall_hold_addr", 64'(tpu_addr), 64'h308);
            chk("stall_hold_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(400, lat);
        chk("stall_word_count", 64'(rx_idx), 64'(NW));

        // 4: start pulsed during WAIT is ignored
        do_reset();
        set_rand_job();
        dsnap = done_total;
        start_job(1'b0);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(400, lat);
        repeat (100) @(posedge clk);
        #1;
        chk("single_done", 64'(done_total - dsnap), 64'd1);
        chk("idle_after_extra", 64'(busy), 64'd0);

        // 5: reset in the 10th WAIT cycle, then a fresh job
        do_reset();
        set_rand_job();
        start_job(1'b0);
        n = 0;
        @(negedge clk);
        while (tpu_addr != 16'h400 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mm_seen", 64'(tpu_addr), 64'h400);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        mc_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",      64'(busy), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_addr",      64'(tpu_addr), 64'd0);
        chk("abort_in_ready",  64'(in_ready), 64'd0);
        set_rand_job();
        start_job(1'b0);
        wait_done(400, lat);
        chk("abort_job_latency", 64'(lat), 64'(EXP_LAT));

        // 6: two identical jobs A = I, B = all-2
        do_reset();
        set_ident_job(1);
        start_job(1'b0);
        wait_done(400, lat);
        chk("acc_first_w0", got[0], 64'h0002_0002_0002_0002);
        start_job(1'b0);
        wait_done(400, lat);
        chk("acc_second_w0",  got[0],  ACC_LIT);
        chk("acc_second_w15", got[15], ACC_LIT);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
